stump_seq_shifter: RTL

STUMP_SEQ_SHIFTER -- requirements
Module: stump_seq_shifter

---
 rtl/stump_seq_shifter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/stump_seq_shifter.sv
// Sequential shifter: ASR/ROR/RRC/LSL/LSR applied one bit per clock over shift_amt steps.
// Define STUMP_SHIFT_BARREL_EN to compute the whole shift in the accepting cycle instead.
module stump_seq_shifter #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] operand_a,
  input  logic             c_in,
  input  logic [2:0]       shift_op,
  input  logic [AMT_W-1:0] shift_amt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] shift_out,
  output logic             c_out
);

  localparam int unsigned MAX_AMT = (1 << AMT_W) - 1;

  localparam logic [2:0] OP_ASR = 3'b001;
  localparam logic [2:0] OP_ROR = 3'b010;
  localparam logic [2:0] OP_RRC = 3'b011;
  localparam logic [2:0] OP_LSL = 3'b100;
  localparam logic [2:0] OP_LSR = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] acc_nxt;
  logic             carry_nxt;
  logic [AMT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       op_q, op_nxt;
  logic             busy_nxt, done_nxt;
  logic             is_noop;

  // One single-bit step; result packed as {carry, value}.
  function automatic logic [WIDTH:0] step_f(input logic [2:0] op,
                                            input logic [WIDTH-1:0] a,
                                            input logic c);
    case (op)
      OP_ASR:  step_f = {a[0], a[WIDTH-1], a[WIDTH-1:1]};
      OP_ROR:  step_f = {a[0], a[0], a[WIDTH-1:1]};
      OP_RRC:  step_f = {a[0], c, a[WIDTH-1:1]};
      OP_LSL:  step_f = {a[WIDTH-1], a[WIDTH-2:0], 1'b0};
      OP_LSR:  step_f = {a[0], 1'b0, a[WIDTH-1:1]};
      default: step_f = {c, a};
    endcase
  endfunction

`ifdef STUMP_SHIFT_BARREL_EN
  // Unrolled iteration so amounts >= WIDTH match the sequential build exactly.
  function automatic logic [WIDTH:0] barrel_f(input logic [2:0] op,
                                              input logic [WIDTH-1:0] a,
                                              input logic c,
                                              input logic [AMT_W-1:0] amt);
    logic [WIDTH:0] r;
    r = {c, a};
    for (int unsigned i = 0; i < MAX_AMT; i++) begin
      if (i < 32'(amt)) r = step_f(op, r[WIDTH-1:0], r[WIDTH]);
    end
    barrel_f = r;
  endfunction
`endif

  assign is_noop = (shift_amt == '0) || (shift_op == 3'b000) || (shift_op[2:1] == 2'b11);

  // Next-state and datapath update.
  always_comb begin
    state_nxt = state;
    acc_nxt   = shift_out;
    carry_nxt = c_out;
    cnt_nxt   = cnt;
    op_nxt    = op_q;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          op_nxt = shift_op;
          if (is_noop) begin
            acc_nxt   = operand_a;
            carry_nxt = c_in;
            state_nxt = S_DONE;
          end else begin
`ifdef STUMP_SHIFT_BARREL_EN
            {carry_nxt, acc_nxt} = barrel_f(shift_op, operand_a, c_in, shift_amt);
            state_nxt = S_DONE;
`else
            acc_nxt   = operand_a;
            carry_nxt = c_in;
            cnt_nxt   = shift_amt;
            state_nxt = S_SHIFT;
`endif
          end
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_SHIFT: begin
        {carry_nxt, acc_nxt} = step_f(op_q, shift_out, c_out);
        cnt_nxt = cnt - AMT_W'(1);
        if (cnt == AMT_W'(1)) state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase
    busy_nxt = (state_nxt == S_SHIFT);
    done_nxt = (state_nxt == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      shift_out <= '0;
      c_out     <= 1'b0;
      cnt       <= '0;
      op_q      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      shift_out <= acc_nxt;
      c_out     <= carry_nxt;
      cnt       <= cnt_nxt;
      op_q      <= op_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
    end
  end

endmodule
